dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Data-side memory subsystem directly downstream of the single-cycle MIPS core.
//  Consumes the core's memwrite/address/writedata and returns readdata in the same cycle.
//  Decodes three regions: word RAM, a GPIO block and a prescaled 32-bit timer with compare flag.
// PARAMETERS
//  RAM_WORDS  64  number of 32-bit RAM words at byte address 0 (power of two, 16..4096)
//  PRESCALE   4   clk cycles per timer tick (>=1; 1 = tick every cycle)
//  GPIO_W     16  width of gpio_out/gpio_in
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  memwrite   in   1       write strobe for the current cycle
//  addr       in   32      byte address (core ALU result)
//  writedata  in   32      store data
//  readdata   out  32      load data, combinational from addr
//  gpio_in    in   GPIO_W  external inputs, asynchronous to clk
//  gpio_out   out  GPIO_W  output register
//  timer_irq  out  1       timer interrupt (see CONFIGURATION)
//  addr_err   out  1       sticky bad-store flag
// BEHAVIOUR
//  Memory map (word aligned):
//  - RAM: 0 .. RAM_WORDS*4-1.
//  - 0xFFFF_0000 GPIO_OUT: R/W.
//  - 0xFFFF_0004 GPIO_IN: RO, 2-flop synchronised.
//  - 0xFFFF_0008 T_COUNT: R/W.
//  - 0xFFFF_000C T_CMP: R/W.
//  - 0xFFFF_0010 T_CTRL: bit0 en, bit1 autoreload, bit2 irq_en.
//  - 0xFFFF_0014 T_STAT: bit0 match, write 1 to clear. Other bits read 0 and are not writable.
//  Reads are combinational, with zero-cycle latency.
//  - Unmapped or misaligned addr (addr[1:0]!=0) reads 0.
//  - Registers narrower than 32 bits are zero-extended.
//  Writes take effect on the rising clk edge when memwrite=1. A write to RO, unmapped or misaligned addr is dropped and sets addr_err.
//  Reset (reset=0, async):
//  - gpio_out=0; sync flops=0; T_COUNT/T_CMP/T_CTRL/T_STAT=0; prescaler=0.
//  - addr_err=0; timer_irq=0.
//  - RAM is not reset. readdata follows addr even during reset.
//  - Reset mid-operation aborts any tick. The next edge after release is a normal cycle.
//  Timer:
//  - Prescaler counts 0..PRESCALE-1 while en=1 and emits a tick on wrap.
//  - en=0 holds the prescaler at 0 and freezes T_COUNT.
//  - On tick, T_COUNT+1 mod 2^32.
//  - If the pre-increment T_COUNT==T_CMP on a tick: set match. With autoreload=1, load T_COUNT=0 instead of incrementing.
//  Simultaneous events:
//  - A CPU write to T_COUNT in the same cycle as a tick: the CPU value wins and the match check is skipped.
//  - A W1C to match in the same cycle as a new match: set wins.
//  - Write T_CTRL.en 1->0: takes effect that edge, with no trailing tick.
//  gpio_in readback latency is 2 clk cycles from an input change.
//  addr_err clears only on reset.
// CONFIGURATION
//  Macro DMEM_MMIO_TIMER_IRQ_EN:
//  - Defined: timer_irq = match & irq_en, registered (one cycle after match sets).
//  - Undefined: timer_irq tied 0, T_CTRL.bit2 not writable and reads 0. Polling T_STAT is unaffected.
// STRUCTURE
//  Shared package dmem_mmio_pkg holds:
//  - MMIO base 0xFFFF_0000 and register offset localparams.
//  - T_CTRL/T_STAT bit-index constants.
//  - A typedef struct for the timer control fields.
//  Sub-module dmem_mmio_timer holds the prescaler, count, compare and match flag. It has a CPU write port and its own irq logic.
//  Top level contains the address decode, RAM array, GPIO registers and read mux.
// TESTING
//  1. RAM: store 0xDEADBEEF @0x10, then load @0x10 -> readdata=0xDEADBEEF. Store @0x12 -> RAM unchanged, addr_err=1.
//  2. GPIO: write 0x0000A5A5 to 0xFFFF_0000 -> gpio_out=0xA5A5. Drive gpio_in=0x1234 -> readdata @0xFFFF_0004 =0x1234 after 2 clks, 0 before.
//  3. Timer, PRESCALE=4: T_CMP=3, T_CTRL=0x3 -> match set on the 16th tick-enabled edge; T_COUNT reads 0 immediately after; repeats every 16 clks.
//  4. W1C race: write 0x1 to T_STAT on the same edge a match occurs -> match stays 1. Next write 0x1 with no match -> 0.
//  5. IRQ: with DMEM_MMIO_TIMER_IRQ_EN and T_CTRL=0x5, T_CMP=0 -> timer_irq=1 one clk after match. Without the macro -> timer_irq stays 0 and T_CTRL reads 0x1.
//  6. Async reset asserted mid-count (T_COUNT=7) -> all registers, gpio_out, addr_err and timer_irq = 0 without a clk edge. RAM contents are retained.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared address map, timer register bit positions and control-field type for dmem_mmio.
// Optional feature macro: DMEM_MMIO_TIMER_IRQ_EN (see dmem_mmio_timer).
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
    localparam logic [7:0]  OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0]  OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0]  OFF_T_COUNT  = 8'h08;
    localparam logic [7:0]  OFF_T_CMP    = 8'h0C;
    localparam logic [7:0]  OFF_T_CTRL   = 8'h10;
    localparam logic [7:0]  OFF_T_STAT   = 8'h14;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int CTRL_IRQ_BIT   = 2;
    localparam int STAT_MATCH_BIT = 0;

    typedef struct packed {
        logic irq_en;
        logic autoreload;
        logic en;
    } timer_ctrl_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_GPIO_OUT,
        SEL_GPIO_IN,
        SEL_T_COUNT,
        SEL_T_CMP,
        SEL_T_CTRL,
        SEL_T_STAT
    } region_e;

    function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]  = c.en;
        w[CTRL_AR_BIT]  = c.autoreload;
        w[CTRL_IRQ_BIT] = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// Prescaled 32-bit timer with compare/match flag and CPU write port.
// DMEM_MMIO_TIMER_IRQ_EN enables the irq_en control bit and the registered irq output.
module dmem_mmio_timer
    import dmem_mmio_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wdata,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic        wr_stat,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output timer_ctrl_t ctrl,
    output logic        match,
    output logic        irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   cmp_q, cmp_d;
    timer_ctrl_t   ctrl_q, ctrl_d;
    logic          match_q, match_d;
    logic          run;
    logic          tick;
    logic          set_match;

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        cmp_d     = cmp_q;
        ctrl_d    = ctrl_q;
        match_d   = match_q;
        tick      = 1'b0;
        set_match = 1'b0;

        // Clearing en suppresses a tick on the very edge of the write.
        run = ctrl_q.en && !(wr_ctrl && !wdata[CTRL_EN_BIT]);

        if (run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = '0;
        end

        if (wr_count) begin
            count_d = wdata;
        end else if (tick) begin
            if (count_q == cmp_q) begin
                set_match = 1'b1;
                count_d   = ctrl_q.autoreload ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_cmp) begin
            cmp_d = wdata;
        end

        if (wr_ctrl) begin
            ctrl_d.en         = wdata[CTRL_EN_BIT];
            ctrl_d.autoreload = wdata[CTRL_AR_BIT];
`ifdef DMEM_MMIO_TIMER_IRQ_EN
            ctrl_d.irq_en     = wdata[CTRL_IRQ_BIT];
`else
            ctrl_d.irq_en     = 1'b0;
`endif
        end

        if (wr_stat && wdata[STAT_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        if (set_match) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
        end
    end

`ifdef DMEM_MMIO_TIMER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = match_q & ctrl_q.irq_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign count = count_q;
    assign cmp   = cmp_q;
    assign ctrl  = ctrl_q;
    assign match = match_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data memory subsystem: word RAM, GPIO and timer behind a combinational read mux.
// Build option: DMEM_MMIO_TIMER_IRQ_EN enables the timer interrupt output.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int PRESCALE  = 4,
    parameter int GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              addr_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    region_e            sel;
    logic [RAM_AW-1:0]  ram_idx;
    logic [31:0]        ram_q [RAM_WORDS];
    logic               ram_we;

    logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0]  sync1_q, sync1_d;
    logic [GPIO_W-1:0]  sync2_q, sync2_d;
    logic               addr_err_q, addr_err_d;

    logic [31:0]        t_count;
    logic [31:0]        t_cmp;
    timer_ctrl_t        t_ctrl;
    logic               t_match;

    assign ram_idx = addr[RAM_AW+1:2];

    // Misaligned addresses never select anything, so they read 0 and fault on store.
    always_comb begin
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr[31:RAM_AW+2] == '0) begin
                sel = SEL_RAM;
            end else if (addr[31:8] == MMIO_BASE[31:8]) begin
                case (addr[7:0])
                    OFF_GPIO_OUT: sel = SEL_GPIO_OUT;
                    OFF_GPIO_IN:  sel = SEL_GPIO_IN;
                    OFF_T_COUNT:  sel = SEL_T_COUNT;
                    OFF_T_CMP:    sel = SEL_T_CMP;
                    OFF_T_CTRL:   sel = SEL_T_CTRL;
                    OFF_T_STAT:   sel = SEL_T_STAT;
                    default:      sel = SEL_NONE;
                endcase
            end
        end
    end

    always_comb begin
        ram_we     = memwrite && (sel == SEL_RAM);
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        addr_err_d = addr_err_q;
        if (memwrite && (sel == SEL_GPIO_OUT)) begin
            gpio_out_d = writedata[GPIO_W-1:0];
        end
        if (memwrite && ((sel == SEL_NONE) || (sel == SEL_GPIO_IN))) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    dmem_mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .wdata    (writedata),
        .wr_count (memwrite && (sel == SEL_T_COUNT)),
        .wr_cmp   (memwrite && (sel == SEL_T_CMP)),
        .wr_ctrl  (memwrite && (sel == SEL_T_CTRL)),
        .wr_stat  (memwrite && (sel == SEL_T_STAT)),
        .count    (t_count),
        .cmp      (t_cmp),
        .ctrl     (t_ctrl),
        .match    (t_match),
        .irq      (timer_irq)
    );

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:      readdata = ram_q[ram_idx];
            SEL_GPIO_OUT: readdata = 32'(gpio_out_q);
            SEL_GPIO_IN:  readdata = 32'(sync2_q);
            SEL_T_COUNT:  readdata = t_count;
            SEL_T_CMP:    readdata = t_cmp;
            SEL_T_CTRL:   readdata = ctrl_to_word(t_ctrl);
            SEL_T_STAT:   readdata = {31'd0, t_match};
            default:      readdata = '0;
        endcase
    end

    assign gpio_out = gpio_out_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, GPIO sync, timer match/autoreload, W1C race, irq, async reset.
module tb_dmem_mmio;

    localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
    localparam logic [31:0] A_T_COUNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_T_CMP    = 32'hFFFF_000C;
    localparam logic [31:0] A_T_CTRL   = 32'hFFFF_0010;
    localparam logic [31:0] A_T_STAT   = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic        timer_irq;
    logic        addr_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] rv;
    logic [31:0] exp_ctrl;
    logic        exp_irq;

    dmem_mmio #(
        .RAM_WORDS (64),
        .PRESCALE  (4),
        .GPIO_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = readdata;
    endtask

    initial begin
`ifdef DMEM_MMIO_TIMER_IRQ_EN
        exp_ctrl = 32'h5;
        exp_irq  = 1'b1;
`else
        exp_ctrl = 32'h1;
        exp_irq  = 1'b0;
`endif
        // Reset state
        #12;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        rd(A_T_COUNT, rv); check("rst_t_count", rv, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // RAM
        wr(32'h10, 32'hDEADBEEF);
        rd(32'h10, rv); check("ram_rd_10", rv, 32'hDEADBEEF);
        wr(32'hFC, 32'h0BADF00D);
        rd(32'hFC, rv); check("ram_rd_last", rv, 32'h0BADF00D);
        check("ram_no_err", 32'(addr_err), 32'h0);
        wr(32'h12, 32'h11111111);
        rd(32'h10, rv); check("ram_misalign_keep", rv, 32'hDEADBEEF);
        rd(32'h12, rv); check("ram_misalign_rd0", rv, 32'h0);
        check("ram_misalign_err", 32'(addr_err), 32'h1);
        rd(32'h100, rv); check("unmapped_rd0", rv, 32'h0);

        // GPIO
        wr(A_GPIO_OUT, 32'h0000A5A5);
        check("gpio_out_pin", 32'(gpio_out), 32'hA5A5);
        rd(A_GPIO_OUT, rv); check("gpio_out_rd", rv, 32'h0000A5A5);
        @(negedge clk);
        gpio_in = 16'h1234;
        rd(A_GPIO_IN, rv); check("gpio_in_0clk", rv, 32'h0);
        @(posedge clk); #1;
        rd(A_GPIO_IN, rv); check("gpio_in_1clk", rv, 32'h0);
        @(posedge clk); #1;
        rd(A_GPIO_IN, rv); check("gpio_in_2clk", rv, 32'h1234);

        // Timer with autoreload: match on the 16th enabled edge, then every 16
        wr(A_T_CMP, 32'd3);
        wr(A_T_CTRL, 32'h3);
        repeat (15) @(posedge clk);
        #1;
        rd(A_T_STAT, rv);  check("tmr_e15_stat", rv, 32'h0);
        rd(A_T_COUNT, rv); check("tmr_e15_count", rv, 32'd3);
        @(posedge clk); #1;
        rd(A_T_STAT, rv);  check("tmr_e16_stat", rv, 32'h1);
        rd(A_T_COUNT, rv); check("tmr_e16_count", rv, 32'd0);
        wr(A_T_STAT, 32'h1);
        rd(A_T_STAT, rv);  check("tmr_w1c_clear", rv, 32'h0);
        repeat (14) @(posedge clk);
        #1;
        rd(A_T_STAT, rv);  check("tmr_e31_stat", rv, 32'h0);
        @(posedge clk); #1;
        rd(A_T_STAT, rv);  check("tmr_e32_stat", rv, 32'h1);
        rd(A_T_COUNT, rv); check("tmr_e32_count", rv, 32'd0);

        // W1C on the same edge as a new match: set wins
        repeat (15) @(posedge clk);
        wr(A_T_STAT, 32'h1);
        rd(A_T_STAT, rv);  check("w1c_race_stat", rv, 32'h1);
        rd(A_T_COUNT, rv); check("w1c_race_count", rv, 32'd0);
        wr(A_T_STAT, 32'h1);
        rd(A_T_STAT, rv);  check("w1c_plain", rv, 32'h0);

        // IRQ
        wr(A_T_CTRL, 32'h0);
        wr(A_T_COUNT, 32'h0);
        wr(A_T_CMP, 32'h0);
        wr(A_T_STAT, 32'h1);
        wr(A_T_CTRL, 32'h5);
        rd(A_T_CTRL, rv); check("irq_ctrl_rd", rv, exp_ctrl);
        repeat (3) @(posedge clk);
        #1;
        rd(A_T_STAT, rv); check("irq_pre_stat", rv, 32'h0);
        @(posedge clk); #1;
        rd(A_T_STAT, rv); check("irq_match", rv, 32'h1);
        check("irq_same_clk", 32'(timer_irq), 32'h0);
        @(posedge clk); #1;
        check("irq_next_clk", 32'(timer_irq), 32'(exp_irq));

        // Async reset mid-count
        wr(A_T_CTRL, 32'h0);
        wr(A_T_COUNT, 32'h0);
        wr(A_T_CMP, 32'h0000FFFF);
        wr(A_T_CTRL, 32'h1);
        repeat (28) @(posedge clk);
        #1;
        rd(A_T_COUNT, rv); check("pre_rst_count", rv, 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check("arst_gpio_out", 32'(gpio_out), 32'h0);
        check("arst_addr_err", 32'(addr_err), 32'h0);
        check("arst_irq", 32'(timer_irq), 32'h0);
        rd(A_T_COUNT, rv); check("arst_t_count", rv, 32'h0);
        rd(A_T_CMP, rv);   check("arst_t_cmp", rv, 32'h0);
        rd(A_T_CTRL, rv);  check("arst_t_ctrl", rv, 32'h0);
        rd(A_T_STAT, rv);  check("arst_t_stat", rv, 32'h0);
        rd(A_GPIO_IN, rv); check("arst_gpio_in", rv, 32'h0);
        rd(32'h10, rv);    check("arst_ram_kept", rv, 32'hDEADBEEF);
        @(negedge clk);
        reset = 1'b1;

        // Normal operation right after release
        wr(A_GPIO_OUT, 32'h0000F0F0);
        check("post_rst_gpio", 32'(gpio_out), 32'hF0F0);
        check("post_rst_no_err", 32'(addr_err), 32'h0);
        wr(A_GPIO_IN, 32'hFFFFFFFF);
        check("ro_store_err", 32'(addr_err), 32'h1);
        rd(A_T_COUNT, rv); check("post_rst_count", rv, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
